// File: rtl/uart7n_tx_arbiter_pkg.sv
// Shared definitions for the uart7n transmit arbiter: FSM encoding, frame width
// and the default watchdog length.
package uart7n_tx_arbiter_pkg;

  localparam int FRAME_W             = 7;
  localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart7n_tx_arbiter_picker.sv
// Combinational round-robin picker: searches upward from the requester after the
// last grant, wrapping around, and returns the first pending one.
module uart7n_rr_picker
  import uart7n_tx_arbiter_pkg::*;
#(
  parameter int P_NUM_REQ = 4,
  parameter int P_IDX_W   = 2
) (
  input  logic [P_NUM_REQ-1:0] req_i,
  input  logic [P_IDX_W-1:0]   last_i,
  output logic [P_NUM_REQ-1:0] onehot_o,
  output logic [P_IDX_W-1:0]   idx_o,
  output logic                 any_o
);

  logic found;

  // Outer loop walks priority order; inner loop keeps every select constant.
  always_comb begin
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int off = 1; off <= P_NUM_REQ; off++) begin
      for (int k = 0; k < P_NUM_REQ; k++) begin
        if (!found && req_i[k] && (k == (int'(last_i) + off) % P_NUM_REQ)) begin
          found       = 1'b1;
          onehot_o[k] = 1'b1;
          idx_o       = P_IDX_W'(k);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart7n_tx_arbiter.sv
// Shares one uart7n transmitter among several requesters: round-robin accept,
// launch pulse, wait for busy then done, with a per-wait-phase watchdog.
module uart7n_tx_arbiter
  import uart7n_tx_arbiter_pkg::*;
#(
  parameter int P_NUM_REQ     = 4,
  parameter int P_TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [P_NUM_REQ-1:0]           req_valid_i,
  input  logic [FRAME_W*P_NUM_REQ-1:0]   req_data_i,
  output logic [P_NUM_REQ-1:0]           req_ready_o,
  output logic [idx_width(P_NUM_REQ)-1:0] grant_id_o,
  output logic [FRAME_W-1:0]             uart_data_o,
  output logic                           uart_enable_tx_o,
  input  logic                           uart_tx_busy_i,
  input  logic                           uart_tx_data_sent_i,
  output logic                           busy_o,
  output logic                           timeout_o,
  output logic [15:0]                    frame_cnt_o
);

  localparam int IDX_W = idx_width(P_NUM_REQ);
  localparam int WD_W  = $clog2(P_TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(P_TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(P_NUM_REQ - 1);

  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [P_NUM_REQ-1:0]   ready_q, ready_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [FRAME_W-1:0]     uart_data_q, uart_data_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;

  logic [P_NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [FRAME_W-1:0]     pick_data;

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  uart7n_rr_picker #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req_valid_i),
    .last_i   (last_grant_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) pick_data = req_data_i[k*FRAME_W +: FRAME_W];
    end
  end

  // The launch pulse is issued together with the accept so it is high
  // for exactly the LAUNCH cycle; watchdog restarts on each wait-state entry.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ready_d      = '0;
    grant_id_d   = grant_id_q;
    uart_data_d  = uart_data_q;
    enable_d     = 1'b0;
    timeout_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    wdog_d       = wdog_q + WD_W'(1);
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (pick_any) begin
          ready_d      = pick_onehot;
          grant_id_d   = pick_idx;
          last_grant_d = pick_idx;
          uart_data_d  = pick_data;
          enable_d     = 1'b1;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_tx_busy_i) begin
          wdog_d  = '0;
          state_d = ST_WAIT_DONE;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (uart_tx_data_sent_i && !uart_tx_busy_i) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_RESET;
      ready_q      <= '0;
      grant_id_q   <= '0;
      uart_data_q  <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      frame_cnt_q  <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ready_q      <= ready_d;
      grant_id_q   <= grant_id_d;
      uart_data_q  <= uart_data_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      frame_cnt_q  <= frame_cnt_d;
      wdog_q       <= wdog_d;
    end
  end

  assign req_ready_o      = ready_q;
  assign grant_id_o       = grant_id_q;
  assign uart_data_o      = uart_data_q;
  assign uart_enable_tx_o = enable_q;
  assign busy_o           = busy_q;
  assign timeout_o        = timeout_q;
  assign frame_cnt_o      = frame_cnt_q;

endmodule

// File: tb/tb_uart7n_tx_arbiter.sv
// Directed bench for uart7n_tx_arbiter: a 4-requester instance with a
// transmitter model and a 3-requester instance with a 16-cycle watchdog.
module tb_uart7n_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [3:0]  valid0 = 4'b0;
  logic [27:0] data0  = {7'h44, 7'h55, 7'h22, 7'h11};
  logic [3:0]  ready0;
  logic [1:0]  grant0;
  logic [6:0]  udata0;
  logic        en0, bsy0, to0;
  logic [15:0] cnt0;
  logic        busy_man = 1'b0, sent_man = 1'b0;
  logic        busy_in0, sent_in0;

  logic [2:0]  valid1 = 3'b0;
  logic [20:0] data1  = {7'h6A, 7'h15, 7'h2B};
  logic [2:0]  ready1;
  logic [1:0]  grant1;
  logic [6:0]  udata1;
  logic        en1, bsy1, to1;
  logic [15:0] cnt1;
  logic        busy_in1 = 1'b0, sent_in1 = 1'b0;

  logic        tx_auto = 1'b0;
  logic        model_busy = 1'b0, model_sent = 1'b0;
  int          model_cnt = 0;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_slice [4] = '{7'h11, 7'h22, 7'h55, 7'h44};

  always #5 clk = ~clk;

  uart7n_tx_arbiter #(.P_NUM_REQ(4), .P_TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid0), .req_data_i(data0),
    .req_ready_o(ready0), .grant_id_o(grant0), .uart_data_o(udata0),
    .uart_enable_tx_o(en0), .uart_tx_busy_i(busy_in0), .uart_tx_data_sent_i(sent_in0),
    .busy_o(bsy0), .timeout_o(to0), .frame_cnt_o(cnt0)
  );

  uart7n_tx_arbiter #(.P_NUM_REQ(3), .P_TIMEOUT_CYC(16)) dut_wd (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid1), .req_data_i(data1),
    .req_ready_o(ready1), .grant_id_o(grant1), .uart_data_o(udata1),
    .uart_enable_tx_o(en1), .uart_tx_busy_i(busy_in1), .uart_tx_data_sent_i(sent_in1),
    .busy_o(bsy1), .timeout_o(to1), .frame_cnt_o(cnt1)
  );

  // Transmitter model: busy for 20 cycles after an enable, then sent held high.
  always @(negedge clk) begin
    if (tx_auto) begin
      if (model_cnt > 0) begin
        model_cnt <= model_cnt - 1;
        if (model_cnt == 1) begin
          model_busy <= 1'b0;
          model_sent <= 1'b1;
        end
      end else if (en0) begin
        model_busy <= 1'b1;
        model_sent <= 1'b0;
        model_cnt  <= 20;
      end
    end
  end

  assign busy_in0 = tx_auto ? model_busy : busy_man;
  assign sent_in0 = tx_auto ? model_sent : sent_man;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    valid0 = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic waitForReady(input string tag);
    int n = 0;
    tick();
    while (ready0 == 4'b0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(ready0 != 4'b0), 32'd1);
  endtask

  task automatic waitForIdle(input string tag);
    int n = 0;
    while (bsy0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(bsy0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset values
    tick(); tick();
    checkOutput("rst_ready", ready0, 0);
    checkOutput("rst_grant", grant0, 0);
    checkOutput("rst_data", udata0, 0);
    checkOutput("rst_enable", en0, 0);
    checkOutput("rst_busy", bsy0, 0);
    checkOutput("rst_timeout", to0, 0);
    checkOutput("rst_cnt", cnt0, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // All four requesting with 20-cycle frames: order 0,1,2,3,0,1
    tx_auto = 1'b1;
    applyStimulus(4'b1111);
    for (int i = 0; i < 6; i++) begin
      waitForReady("rr_ready_seen");
      checkOutput("rr_ready", ready0, 32'(1 << (i % 4)));
      checkOutput("rr_grant", grant0, 32'(i % 4));
      checkOutput("rr_data", udata0, exp_slice[i % 4]);
      checkOutput("rr_enable", en0, 1);
      if (i == 5) applyStimulus(4'b0000);
    end
    waitForIdle("rr_idle");
    checkOutput("rr_cnt", cnt0, 6);
    tx_auto  = 1'b0;
    busy_man = 1'b0;
    sent_man = 1'b0;
    tick();

    // Single request on requester 2 (last grant was 1)
    applyStimulus(4'b0100);
    tick();
    checkOutput("single_ready", ready0, 4'b0100);
    checkOutput("single_grant", grant0, 2);
    checkOutput("single_data", udata0, 7'h55);
    checkOutput("single_enable", en0, 1);
    checkOutput("single_busy", bsy0, 1);
    applyStimulus(4'b0000);
    tick();
    checkOutput("single_ready_drop", ready0, 0);
    checkOutput("single_enable_drop", en0, 0);
    busy_man = 1'b1;
    tick();
    busy_man = 1'b0;
    sent_man = 1'b1;
    tick();
    checkOutput("single_cnt", cnt0, 7);
    checkOutput("single_idle", bsy0, 0);
    checkOutput("single_data_hold", udata0, 7'h55);

    // Stale sent held high must not complete the next frame early
    applyStimulus(4'b0001);
    tick();
    checkOutput("stale_ready", ready0, 4'b0001);
    checkOutput("stale_grant", grant0, 0);
    applyStimulus(4'b0010);
    tick();
    tick();
    applyStimulus(4'b1000);
    repeat (4) tick();
    checkOutput("stale_wait_busy", bsy0, 1);
    checkOutput("stale_cnt_hold", cnt0, 7);
    checkOutput("stale_no_accept", ready0, 0);
    busy_man = 1'b1;
    tick();
    tick();
    checkOutput("stale_wait_done", bsy0, 1);
    checkOutput("stale_cnt_hold2", cnt0, 7);
    busy_man = 1'b0;
    tick();
    checkOutput("stale_cnt", cnt0, 8);
    checkOutput("stale_idle", bsy0, 0);

    // Queued requester 3 wins; withdrawn requester 1 is ignored
    tick();
    checkOutput("queued_ready", ready0, 4'b1000);
    checkOutput("queued_grant", grant0, 3);
    checkOutput("queued_data", udata0, 7'h44);
    applyStimulus(4'b0000);

    // Reset while in WAIT_DONE
    sent_man = 1'b0;
    tick();
    busy_man = 1'b1;
    tick();
    checkOutput("midrst_pre_busy", bsy0, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", ready0, 0);
    checkOutput("midrst_grant", grant0, 0);
    checkOutput("midrst_data", udata0, 0);
    checkOutput("midrst_enable", en0, 0);
    checkOutput("midrst_busy", bsy0, 0);
    checkOutput("midrst_timeout", to0, 0);
    checkOutput("midrst_cnt", cnt0, 0);
    busy_man = 1'b0;
    applyStimulus(4'b1000);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checkOutput("release_sync1", ready0, 0);
    tick();
    checkOutput("release_sync2", ready0, 0);
    tick();
    checkOutput("release_ready", ready0, 4'b1000);
    checkOutput("release_grant", grant0, 3);
    applyStimulus(4'b0000);

    // Frame counter wrap
    tick();
    busy_man = 1'b1;
    tick();
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    busy_man = 1'b0;
    sent_man = 1'b1;
    tick();
    checkOutput("wrap_cnt", cnt0, 16'h0000);
    checkOutput("wrap_idle", bsy0, 0);

    // Watchdog: 16-cycle limit, transmitter never goes busy
    valid1 = 3'b100;
    tick();
    checkOutput("wd_ready", ready1, 3'b100);
    checkOutput("wd_grant", grant1, 2);
    checkOutput("wd_data", udata1, 7'h6A);
    valid1 = 3'b000;
    tick();
    repeat (15) tick();
    checkOutput("wd_no_early_timeout", to1, 0);
    checkOutput("wd_still_busy", bsy1, 1);
    checkOutput("wd_no_enable", en1, 0);
    tick();
    checkOutput("wd_timeout", to1, 1);
    checkOutput("wd_idle", bsy1, 0);
    checkOutput("wd_cnt", cnt1, 0);
    tick();
    checkOutput("wd_timeout_pulse", to1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
